// File: rtl/req_ack_responder_pkg.sv
// Shared types and constants for the request/acknowledge responder.
package req_ack_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAT,
    FULL_WAIT,
    ACK,
    REL
  } state_e;

  // Cycles from a request rise to acknowledge when the FIFO has room.
  localparam int REQ_ACK_LATENCY = 2;

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/req_ack_responder_if.sv
// Initiator-side request/acknowledge signals plus the downstream valid/ready port.
interface req_ack_responder_if
  import req_ack_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) ();

  localparam int LVL_W = level_w(FIFO_DEPTH);

  logic              request;
  logic [DATA_W-1:0] data;
  logic              acknowledge;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [LVL_W-1:0]  fifo_level;
  logic              stall;
  logic              abort_pulse;

  modport master (
    output request, data, out_ready,
    input  acknowledge, out_valid, out_data, fifo_level, stall, abort_pulse
  );

  modport slave (
    input  request, data, out_ready,
    output acknowledge, out_valid, out_data, fifo_level, stall, abort_pulse
  );

endinterface

// File: rtl/req_ack_responder_sync_fifo.sv
// First-word-fall-through FIFO; head reads as zero while empty.
module sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push_i,
  input  logic [DATA_W-1:0]                push_data_i,
  input  logic                             pop_i,
  output logic                             valid_o,
  output logic [DATA_W-1:0]                head_o,
  output logic [$clog2(FIFO_DEPTH):0]      level_o,
  output logic                             full_o
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              push_ok, pop_ok;

  assign valid_o = (level_q != '0);
  assign full_o  = (level_q == LVL_W'(FIFO_DEPTH));
  assign pop_ok  = pop_i && valid_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign head_o  = valid_o ? mem[rd_ptr_q] : '0;
  assign level_o = level_q;

  always_comb begin
    level_d = level_q;
    if (push_ok && !pop_ok) begin
      level_d = level_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  // Storage is left unreset; stale words stay hidden behind the level count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/req_ack_responder.sv
// Responder FSM: captures initiator data into the FIFO and acknowledges after a fixed latency.
module req_ack_responder
  import req_ack_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int ACK_MIN_HIGH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  req_ack_responder_if.slave  bus
);

  localparam int LVL_W  = level_w(FIFO_DEPTH);
  localparam int HOLD_W = $clog2(ACK_MIN_HIGH + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(ACK_MIN_HIGH);

  state_e             state_q, state_d;
  logic               req_prev_q;
  logic               ack_q, ack_d;
  logic               abort_q, abort_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               push, pop, full, has_space, out_valid;
  logic [DATA_W-1:0]  head;
  logic [LVL_W-1:0]   level;

  sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (bus.data),
    .pop_i       (pop),
    .valid_o     (out_valid),
    .head_o      (head),
    .level_o     (level),
    .full_o      (full)
  );

  assign pop       = out_valid && bus.out_ready;
  // A pop in the same cycle frees the slot the push is about to take.
  assign has_space = !full || pop;

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    abort_d = 1'b0;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (bus.request && !req_prev_q) state_d = LAT;
      end
      LAT, FULL_WAIT: begin
        if (!bus.request) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else if (has_space) begin
          push    = 1'b1;
          state_d = ACK;
          hold_d  = HOLD_W'(1);
        end else begin
          state_d = FULL_WAIT;
        end
      end
      ACK: begin
        if (!bus.request && hold_q >= HOLD_MAX) begin
          state_d = REL;
        end else if (hold_q < HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
        end
      end
      REL:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ack_d = (state_d == ACK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_prev_q <= 1'b0;
      ack_q      <= 1'b0;
      abort_q    <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      req_prev_q <= bus.request;
      ack_q      <= ack_d;
      abort_q    <= abort_d;
      hold_q     <= hold_d;
    end
  end

  assign bus.acknowledge = ack_q;
  assign bus.abort_pulse = abort_q;
  assign bus.stall       = (state_q == FULL_WAIT);
  assign bus.out_valid   = out_valid;
  assign bus.out_data    = head;
  assign bus.fifo_level  = level;

endmodule
